// File: rtl/cache_bypass_rsp_pkg.sv
// Shared definitions for the bypass-read return path: DRAM tag prefix decode
// and the merge-source encoding used by the output round-robin.
package cache_bypass_rsp_pkg;

  localparam int         BYPASS_PREFIX_W   = 3;
  localparam logic [2:0] BYPASS_TAG_PREFIX = 3'b111;

  typedef enum logic {
    SRC_CACHE  = 1'b0,
    SRC_BYPASS = 1'b1
  } rsp_src_e;

  function automatic logic is_bypass_tag(input logic [BYPASS_PREFIX_W-1:0] hi);
    return hi == BYPASS_TAG_PREFIX;
  endfunction

endpackage

// File: rtl/cache_bypass_rsp_buf.sv
// Two-entry valid/ready FIFO holding extracted bypass words until the core
// response port takes them. A push while full is accepted only alongside a pop.
module cache_bypass_rsp_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push_valid,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop_ready,
  output logic [W-1:0] o_pop_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_full     = (r_cnt == 2'd2);
  assign o_empty    = (r_cnt == 2'd0);
  assign o_pop_data = r_mem[r_rptr];
  assign w_pop      = i_pop_ready & !o_empty;
  assign w_push     = i_push_valid & (!o_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end

endmodule

// File: rtl/cache_bypass_rsp.sv
// Bypass read return path: tracks outstanding uncached reads, peels bypass
// responses off the DRAM stream as single words and merges them with cache responses.
module cache_bypass_rsp
  import cache_bypass_rsp_pkg::*;
#(
  parameter int CACHE_ID         = 0,
  parameter int NUM_REQS         = 4,
  parameter int CACHE_LINE_SIZE  = 64,
  parameter int WORD_SIZE        = 4,
  parameter int CORE_TAG_WIDTH   = 3,
  parameter int CORE_TAG_ID_BITS = 3,
  parameter int DRAM_TAG_WIDTH   = 26,
  localparam int WORDS   = CACHE_LINE_SIZE / WORD_SIZE,
  localparam int WSEL_W  = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int WORD_W  = 8 * WORD_SIZE,
  localparam int LINE_W  = 8 * CACHE_LINE_SIZE,
  localparam int LANE_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNT_W   = CORE_TAG_ID_BITS + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  input  logic                         alloc_rw,
  input  logic [LANE_W-1:0]            alloc_lane,
  input  logic [WSEL_W-1:0]            alloc_wsel,
  input  logic [CORE_TAG_WIDTH-1:0]    alloc_tag,
  input  logic                         dram_rsp_valid,
  input  logic [LINE_W-1:0]            dram_rsp_data,
  input  logic [DRAM_TAG_WIDTH-1:0]    dram_rsp_tag,
  output logic                         dram_rsp_ready,
  output logic                         cache_dram_rsp_valid,
  output logic [LINE_W-1:0]            cache_dram_rsp_data,
  output logic [DRAM_TAG_WIDTH-1:0]    cache_dram_rsp_tag,
  input  logic                         cache_dram_rsp_ready,
  input  logic [NUM_REQS-1:0]          cache_core_rsp_valid,
  input  logic [NUM_REQS*WORD_W-1:0]   cache_core_rsp_data,
  input  logic [CORE_TAG_WIDTH-1:0]    cache_core_rsp_tag,
  output logic                         cache_core_rsp_ready,
  output logic [NUM_REQS-1:0]          core_rsp_valid,
  output logic [NUM_REQS*WORD_W-1:0]   core_rsp_data,
  output logic [CORE_TAG_WIDTH-1:0]    core_rsp_tag,
  input  logic                         core_rsp_ready,
  output logic [CNT_W-1:0]             pending_cnt,
  output logic                         bypass_err
);

  localparam int ENTRIES = 2 ** CORE_TAG_ID_BITS;
  localparam int ID_W    = CORE_TAG_ID_BITS;

  typedef struct packed {
    logic [LANE_W-1:0]         lane;
    logic [WSEL_W-1:0]         wsel;
    logic [CORE_TAG_WIDTH-1:0] tag;
  } byp_ent_t;

  typedef struct packed {
    logic [LANE_W-1:0]         lane;
    logic [WORD_W-1:0]         word;
    logic [CORE_TAG_WIDTH-1:0] tag;
  } byp_rsp_t;

  byp_ent_t           r_tbl [ENTRIES];
  logic [ENTRIES-1:0] r_tbl_vld;
  logic [CNT_W-1:0]   r_pending;
  logic               r_err;
  rsp_src_e           r_last;

  logic               w_is_byp;
  logic [ID_W-1:0]    w_rsp_idx;
  logic [ID_W-1:0]    w_alloc_idx;
  logic               w_byp_fire;
  logic               w_free;
  logic               w_drop;
  logic               w_alloc;
  logic               w_alloc_dup;
  logic               w_alloc_new;
  byp_ent_t           w_rsp_ent;
  logic [WORD_W-1:0]  w_rsp_word;
  byp_rsp_t           w_rsp_p0;
  byp_rsp_t           w_rsp_p1;
  logic               w_vld_p1;
  logic               w_buf_full;
  logic               w_buf_empty;
  logic               w_cache_vld;
  logic               w_grant_byp;
  logic               w_buf_pop;

  assign w_is_byp    = is_bypass_tag(dram_rsp_tag[DRAM_TAG_WIDTH-1 -: BYPASS_PREFIX_W]);
  assign w_rsp_idx   = dram_rsp_tag[ID_W-1:0];
  assign w_alloc_idx = alloc_tag[ID_W-1:0];
  assign w_rsp_ent   = r_tbl[w_rsp_idx];

  assign cache_dram_rsp_valid = dram_rsp_valid & !w_is_byp;
  assign cache_dram_rsp_data  = dram_rsp_data;
  assign cache_dram_rsp_tag   = dram_rsp_tag;
  assign dram_rsp_ready       = w_is_byp ? !w_buf_full : cache_dram_rsp_ready;

  assign w_byp_fire  = dram_rsp_valid & w_is_byp & !w_buf_full;
  assign w_free      = w_byp_fire & r_tbl_vld[w_rsp_idx];
  assign w_drop      = w_byp_fire & !r_tbl_vld[w_rsp_idx];
  assign w_alloc     = alloc_valid & !alloc_rw;
  // A free of the same slot in this cycle happens first, so that is not a double allocate.
  assign w_alloc_dup = w_alloc & r_tbl_vld[w_alloc_idx] & !(w_free && (w_rsp_idx == w_alloc_idx));
  assign w_alloc_new = w_alloc & !w_alloc_dup;

  always_comb begin
    w_rsp_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (w_rsp_ent.wsel == k[WSEL_W-1:0]) w_rsp_word = dram_rsp_data[k*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tbl_vld <= '0;
    end else begin
      if (w_free)  r_tbl_vld[w_rsp_idx]   <= 1'b0;
      if (w_alloc) r_tbl_vld[w_alloc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) r_tbl[w_alloc_idx] <= '{lane: alloc_lane, wsel: alloc_wsel, tag: alloc_tag};
  end

  // Overwrites do not add an entry, keeping the count equal to live table entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_alloc_new && !w_free)      r_pending <= r_pending + CNT_W'(1);
      else if (w_free && !w_alloc_new) r_pending <= r_pending - CNT_W'(1);
      if (w_alloc_dup || w_drop) r_err <= 1'b1;
    end
  end

  assign pending_cnt = r_pending;
  assign bypass_err  = r_err;

  // p0 -> p1: extracted word is registered in the response buffer
  assign w_rsp_p0 = '{lane: w_rsp_ent.lane, word: w_rsp_word, tag: w_rsp_ent.tag};

  cache_bypass_rsp_buf #(
    .W ($bits(byp_rsp_t))
  ) u_buf (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (w_free),
    .i_push_data  (w_rsp_p0),
    .i_pop_ready  (w_buf_pop),
    .o_pop_data   (w_rsp_p1),
    .o_full       (w_buf_full),
    .o_empty      (w_buf_empty)
  );

  assign w_vld_p1    = !w_buf_empty;
  assign w_cache_vld = |cache_core_rsp_valid;
  assign w_grant_byp = w_vld_p1 & (!w_cache_vld | (r_last == SRC_CACHE));
  assign w_buf_pop   = w_grant_byp & core_rsp_ready;

  always_comb begin
    core_rsp_valid       = cache_core_rsp_valid;
    core_rsp_data        = cache_core_rsp_data;
    core_rsp_tag         = cache_core_rsp_tag;
    cache_core_rsp_ready = core_rsp_ready;
    if (w_grant_byp) begin
      core_rsp_valid                                    = '0;
      core_rsp_valid[w_rsp_p1.lane]                     = 1'b1;
      core_rsp_data                                     = '0;
      core_rsp_data[w_rsp_p1.lane*WORD_W +: WORD_W]     = w_rsp_p1.word;
      core_rsp_tag                                      = w_rsp_p1.tag;
      cache_core_rsp_ready                              = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= SRC_CACHE;
    end else if (w_buf_pop) begin
      r_last <= SRC_BYPASS;
    end else if (w_cache_vld && core_rsp_ready) begin
      r_last <= SRC_CACHE;
    end
  end

endmodule

// File: tb/tb_cache_bypass_rsp.sv
// Bench for cache_bypass_rsp: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_cache_bypass_rsp;

  localparam int NUM_REQS = 4;
  localparam int WORD_W   = 32;
  localparam int WORDS    = 16;
  localparam int LINE_W   = 512;
  localparam int ENTRIES  = 8;
  localparam int DTAG_W   = 26;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        alloc_valid;
  logic                        alloc_rw;
  logic [1:0]                  alloc_lane;
  logic [3:0]                  alloc_wsel;
  logic [2:0]                  alloc_tag;
  logic                        dram_rsp_valid;
  logic [LINE_W-1:0]           dram_rsp_data;
  logic [DTAG_W-1:0]           dram_rsp_tag;
  logic                        dram_rsp_ready;
  logic                        cache_dram_rsp_valid;
  logic [LINE_W-1:0]           cache_dram_rsp_data;
  logic [DTAG_W-1:0]           cache_dram_rsp_tag;
  logic                        cache_dram_rsp_ready;
  logic [NUM_REQS-1:0]         cache_core_rsp_valid;
  logic [NUM_REQS*WORD_W-1:0]  cache_core_rsp_data;
  logic [2:0]                  cache_core_rsp_tag;
  logic                        cache_core_rsp_ready;
  logic [NUM_REQS-1:0]         core_rsp_valid;
  logic [NUM_REQS*WORD_W-1:0]  core_rsp_data;
  logic [2:0]                  core_rsp_tag;
  logic                        core_rsp_ready;
  logic [3:0]                  pending_cnt;
  logic                        bypass_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] word;
    logic [2:0]  tag;
  } rsp_t;

  logic       m_vld  [ENTRIES];
  logic [1:0] m_lane [ENTRIES];
  logic [3:0] m_wsel [ENTRIES];
  logic [2:0] m_tag  [ENTRIES];
  rsp_t       m_q[$];
  bit         m_last_byp;
  bit         m_err;

  always #5 clk = ~clk;

  cache_bypass_rsp dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_rw             (alloc_rw),
    .alloc_lane           (alloc_lane),
    .alloc_wsel           (alloc_wsel),
    .alloc_tag            (alloc_tag),
    .dram_rsp_valid       (dram_rsp_valid),
    .dram_rsp_data        (dram_rsp_data),
    .dram_rsp_tag         (dram_rsp_tag),
    .dram_rsp_ready       (dram_rsp_ready),
    .cache_dram_rsp_valid (cache_dram_rsp_valid),
    .cache_dram_rsp_data  (cache_dram_rsp_data),
    .cache_dram_rsp_tag   (cache_dram_rsp_tag),
    .cache_dram_rsp_ready (cache_dram_rsp_ready),
    .cache_core_rsp_valid (cache_core_rsp_valid),
    .cache_core_rsp_data  (cache_core_rsp_data),
    .cache_core_rsp_tag   (cache_core_rsp_tag),
    .cache_core_rsp_ready (cache_core_rsp_ready),
    .core_rsp_valid       (core_rsp_valid),
    .core_rsp_data        (core_rsp_data),
    .core_rsp_tag         (core_rsp_tag),
    .core_rsp_ready       (core_rsp_ready),
    .pending_cnt          (pending_cnt),
    .bypass_err           (bypass_err)
  );

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < WORDS; k++) l[k*WORD_W +: WORD_W] = $urandom;
    return l;
  endfunction

  function automatic logic [DTAG_W-1:0] byp_tag(input int id);
    logic [DTAG_W-1:0] t;
    t = '0;
    t[DTAG_W-1 -: 3] = 3'b111;
    t[2:0] = id[2:0];
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_rw = 1'b0; alloc_lane = '0; alloc_wsel = '0; alloc_tag = '0;
    dram_rsp_valid = 1'b0; dram_rsp_data = '0; dram_rsp_tag = '0;
    cache_dram_rsp_ready = 1'b1;
    cache_core_rsp_valid = '0; cache_core_rsp_data = '0; cache_core_rsp_tag = '0;
    core_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic alloc1(input int lane, input int wsel, input int tag);
    alloc_valid = 1'b1; alloc_rw = 1'b0;
    alloc_lane = 2'(lane); alloc_wsel = 4'(wsel); alloc_tag = 3'(tag);
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pending_cnt !== 4'd0) $display("FAIL rst_pending: got %0d exp 0", pending_cnt); else n_pass++;
    n_checks++; if (bypass_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", bypass_err); else n_pass++;
    n_checks++; if (core_rsp_valid !== 4'b0000) $display("FAIL rst_core_valid: got %b exp 0000", core_rsp_valid); else n_pass++;
    n_checks++; if (cache_dram_rsp_valid !== 1'b0) $display("FAIL rst_cdram_valid: got %b exp 0", cache_dram_rsp_valid); else n_pass++;
    alloc1(0, 0, 4);
    n_checks++; if (pending_cnt !== 4'd1) $display("FAIL rst_alloc_pending: got %0d exp 1", pending_cnt); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (pending_cnt !== 4'd0) $display("FAIL rst_mid_pending: got %0d exp 0", pending_cnt); else n_pass++;
    dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(4); dram_rsp_data = rand_line();
    step();
    dram_rsp_valid = 1'b0;
    n_checks++; if (bypass_err !== 1'b1) $display("FAIL rst_late_err: got %b exp 1", bypass_err); else n_pass++;
    n_checks++; if (core_rsp_valid !== 4'b0000) $display("FAIL rst_late_valid: got %b exp 0000", core_rsp_valid); else n_pass++;
  endtask

  task automatic test_bypass_read();
    logic [LINE_W-1:0] line;
    do_reset();
    alloc1(2, 5, 3);
    n_checks++; if (pending_cnt !== 4'd1) $display("FAIL byp_pending1: got %0d exp 1", pending_cnt); else n_pass++;
    line = rand_line();
    line[5*WORD_W +: WORD_W] = 32'hDEADBEEF;
    dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(3); dram_rsp_data = line;
    #1;
    n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL byp_ready: got %b exp 1", dram_rsp_ready); else n_pass++;
    n_checks++; if (cache_dram_rsp_valid !== 1'b0) $display("FAIL byp_no_cache: got %b exp 0", cache_dram_rsp_valid); else n_pass++;
    n_checks++; if (core_rsp_valid !== 4'b0000) $display("FAIL byp_latency: got %b exp 0000", core_rsp_valid); else n_pass++;
    step();
    dram_rsp_valid = 1'b0;
    n_checks++; if (core_rsp_valid !== 4'b0100) $display("FAIL byp_valid: got %b exp 0100", core_rsp_valid); else n_pass++;
    n_checks++; if (core_rsp_data !== {32'h0, 32'hDEADBEEF, 64'h0}) $display("FAIL byp_data: got %h exp lane2=deadbeef", core_rsp_data); else n_pass++;
    n_checks++; if (core_rsp_tag !== 3'd3) $display("FAIL byp_tag: got %0d exp 3", core_rsp_tag); else n_pass++;
    n_checks++; if (pending_cnt !== 4'd0) $display("FAIL byp_pending0: got %0d exp 0", pending_cnt); else n_pass++;
    step();
    n_checks++; if (core_rsp_valid !== 4'b0000) $display("FAIL byp_popped: got %b exp 0000", core_rsp_valid); else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [LINE_W-1:0] line;
    do_reset();
    line = rand_line();
    dram_rsp_valid = 1'b1; dram_rsp_tag = 26'h12345; dram_rsp_data = line;
    #1;
    n_checks++; if (cache_dram_rsp_valid !== 1'b1) $display("FAIL pt_valid: got %b exp 1", cache_dram_rsp_valid); else n_pass++;
    n_checks++; if (cache_dram_rsp_data !== line) $display("FAIL pt_data: got %h exp %h", cache_dram_rsp_data[63:0], line[63:0]); else n_pass++;
    n_checks++; if (cache_dram_rsp_tag !== 26'h12345) $display("FAIL pt_tag: got %h exp 12345", cache_dram_rsp_tag); else n_pass++;
    n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL pt_ready1: got %b exp 1", dram_rsp_ready); else n_pass++;
    cache_dram_rsp_ready = 1'b0;
    #1;
    n_checks++; if (dram_rsp_ready !== 1'b0) $display("FAIL pt_ready0: got %b exp 0", dram_rsp_ready); else n_pass++;
    cache_dram_rsp_ready = 1'b1;
    step();
    dram_rsp_valid = 1'b0;
    n_checks++; if (core_rsp_valid !== 4'b0000) $display("FAIL pt_core: got %b exp 0000", core_rsp_valid); else n_pass++;
    n_checks++; if (bypass_err !== 1'b0) $display("FAIL pt_err: got %b exp 0", bypass_err); else n_pass++;
  endtask

  task automatic test_empty_entry();
    do_reset();
    dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(6); dram_rsp_data = rand_line();
    #1;
    n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL empty_ready_pre: got %b exp 1", dram_rsp_ready); else n_pass++;
    step();
    n_checks++; if (bypass_err !== 1'b1) $display("FAIL empty_err: got %b exp 1", bypass_err); else n_pass++;
    n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL empty_ready_post: got %b exp 1", dram_rsp_ready); else n_pass++;
    n_checks++; if (core_rsp_valid !== 4'b0000) $display("FAIL empty_valid: got %b exp 0000", core_rsp_valid); else n_pass++;
    dram_rsp_valid = 1'b0;
    step();
    n_checks++; if (pending_cnt !== 4'd0) $display("FAIL empty_pending: got %0d exp 0", pending_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] l0, l1, l2;
    do_reset();
    alloc1(0, 1, 0);
    alloc1(1, 2, 1);
    alloc1(3, 4, 2);
    l0 = rand_line(); l1 = rand_line(); l2 = rand_line();
    core_rsp_ready = 1'b0;
    dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(0); dram_rsp_data = l0;
    #1;
    n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL b2b_ready0: got %b exp 1", dram_rsp_ready); else n_pass++;
    step();
    dram_rsp_tag = byp_tag(1); dram_rsp_data = l1;
    #1;
    n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL b2b_ready1: got %b exp 1", dram_rsp_ready); else n_pass++;
    step();
    dram_rsp_tag = byp_tag(2); dram_rsp_data = l2;
    #1;
    n_checks++; if (dram_rsp_ready !== 1'b0) $display("FAIL b2b_full: got %b exp 0", dram_rsp_ready); else n_pass++;
    step();
    n_checks++; if (dram_rsp_ready !== 1'b0) $display("FAIL b2b_full_hold: got %b exp 0", dram_rsp_ready); else n_pass++;
    n_checks++; if (core_rsp_valid !== 4'b0001) $display("FAIL b2b_v0: got %b exp 0001", core_rsp_valid); else n_pass++;
    n_checks++; if (core_rsp_data[31:0] !== l0[1*WORD_W +: WORD_W]) $display("FAIL b2b_d0: got %h exp %h", core_rsp_data[31:0], l0[1*WORD_W +: WORD_W]); else n_pass++;
    core_rsp_ready = 1'b1;
    #1;
    n_checks++; if (dram_rsp_ready !== 1'b0) $display("FAIL b2b_full_pop: got %b exp 0", dram_rsp_ready); else n_pass++;
    step();
    n_checks++; if (core_rsp_valid !== 4'b0010) $display("FAIL b2b_v1: got %b exp 0010", core_rsp_valid); else n_pass++;
    n_checks++; if (core_rsp_data[63:32] !== l1[2*WORD_W +: WORD_W]) $display("FAIL b2b_d1: got %h exp %h", core_rsp_data[63:32], l1[2*WORD_W +: WORD_W]); else n_pass++;
    n_checks++; if (core_rsp_tag !== 3'd1) $display("FAIL b2b_t1: got %0d exp 1", core_rsp_tag); else n_pass++;
    n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL b2b_ready2: got %b exp 1", dram_rsp_ready); else n_pass++;
    step();
    dram_rsp_valid = 1'b0;
    n_checks++; if (core_rsp_valid !== 4'b1000) $display("FAIL b2b_v2: got %b exp 1000", core_rsp_valid); else n_pass++;
    n_checks++; if (core_rsp_data[127:96] !== l2[4*WORD_W +: WORD_W]) $display("FAIL b2b_d2: got %h exp %h", core_rsp_data[127:96], l2[4*WORD_W +: WORD_W]); else n_pass++;
    n_checks++; if (core_rsp_tag !== 3'd2) $display("FAIL b2b_t2: got %0d exp 2", core_rsp_tag); else n_pass++;
    step();
    n_checks++; if (core_rsp_valid !== 4'b0000) $display("FAIL b2b_drain: got %b exp 0000", core_rsp_valid); else n_pass++;
    n_checks++; if (pending_cnt !== 4'd0) $display("FAIL b2b_pending: got %0d exp 0", pending_cnt); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [LINE_W-1:0]          ln [6];
    logic [NUM_REQS*WORD_W-1:0] cdata;
    logic [NUM_REQS*WORD_W-1:0] edata;
    int id;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc1(i % 4, i, i);
      ln[i] = rand_line();
    end
    core_rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(i); dram_rsp_data = ln[i];
      step();
    end
    dram_rsp_valid = 1'b0;
    cdata = {$urandom, $urandom, $urandom, $urandom};
    cache_core_rsp_valid = 4'b1111; cache_core_rsp_data = cdata; cache_core_rsp_tag = 3'd7;
    core_rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 1) begin
        id = 2 + (c - 1) / 2;
        dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(id); dram_rsp_data = ln[id];
      end else begin
        dram_rsp_valid = 1'b0;
      end
      #1;
      if (c % 2 == 0) begin
        id = c / 2;
        edata = '0;
        edata[(id % 4)*WORD_W +: WORD_W] = ln[id][id*WORD_W +: WORD_W];
        n_checks++; if (core_rsp_valid !== 4'(1 << (id % 4))) $display("FAIL rr_byp_valid c%0d: got %b exp %b", c, core_rsp_valid, 4'(1 << (id % 4))); else n_pass++;
        n_checks++; if (core_rsp_data !== edata) $display("FAIL rr_byp_data c%0d: got %h exp %h", c, core_rsp_data, edata); else n_pass++;
        n_checks++; if (core_rsp_tag !== 3'(id)) $display("FAIL rr_byp_tag c%0d: got %0d exp %0d", c, core_rsp_tag, id); else n_pass++;
        n_checks++; if (cache_core_rsp_ready !== 1'b0) $display("FAIL rr_byp_stall c%0d: got %b exp 0", c, cache_core_rsp_ready); else n_pass++;
      end else begin
        n_checks++; if (core_rsp_valid !== 4'b1111) $display("FAIL rr_cache_valid c%0d: got %b exp 1111", c, core_rsp_valid); else n_pass++;
        n_checks++; if (core_rsp_data !== cdata) $display("FAIL rr_cache_data c%0d: got %h exp %h", c, core_rsp_data, cdata); else n_pass++;
        n_checks++; if (cache_core_rsp_ready !== 1'b1) $display("FAIL rr_cache_ready c%0d: got %b exp 1", c, cache_core_rsp_ready); else n_pass++;
        n_checks++; if (dram_rsp_ready !== 1'b1) $display("FAIL rr_refill c%0d: got %b exp 1", c, dram_rsp_ready); else n_pass++;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    logic [LINE_W-1:0] line;
    logic [31:0] wa, wb;
    do_reset();
    alloc1(1, 2, 1);
    n_checks++; if (pending_cnt !== 4'd1) $display("FAIL same_pending_pre: got %0d exp 1", pending_cnt); else n_pass++;
    line = rand_line();
    wa = $urandom; wb = $urandom;
    line[2*WORD_W +: WORD_W] = wa;
    line[7*WORD_W +: WORD_W] = wb;
    alloc_valid = 1'b1; alloc_rw = 1'b0; alloc_lane = 2'd3; alloc_wsel = 4'd7; alloc_tag = 3'd1;
    dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(1); dram_rsp_data = line;
    step();
    alloc_valid = 1'b0; dram_rsp_valid = 1'b0;
    n_checks++; if (core_rsp_valid !== 4'b0010) $display("FAIL same_old_valid: got %b exp 0010", core_rsp_valid); else n_pass++;
    n_checks++; if (core_rsp_data[63:32] !== wa) $display("FAIL same_old_data: got %h exp %h", core_rsp_data[63:32], wa); else n_pass++;
    n_checks++; if (pending_cnt !== 4'd1) $display("FAIL same_pending: got %0d exp 1", pending_cnt); else n_pass++;
    n_checks++; if (bypass_err !== 1'b0) $display("FAIL same_err: got %b exp 0", bypass_err); else n_pass++;
    dram_rsp_valid = 1'b1; dram_rsp_tag = byp_tag(1); dram_rsp_data = line;
    step();
    dram_rsp_valid = 1'b0;
    n_checks++; if (core_rsp_valid !== 4'b1000) $display("FAIL same_new_valid: got %b exp 1000", core_rsp_valid); else n_pass++;
    n_checks++; if (core_rsp_data[127:96] !== wb) $display("FAIL same_new_data: got %h exp %h", core_rsp_data[127:96], wb); else n_pass++;
    n_checks++; if (pending_cnt !== 4'd0) $display("FAIL same_pending_post: got %0d exp 0", pending_cnt); else n_pass++;
    n_checks++; if (bypass_err !== 1'b0) $display("FAIL same_err_post: got %b exp 0", bypass_err); else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic                       byp, e_ready, gb, e_cr;
    logic [3:0]                 e_v;
    logic [NUM_REQS*WORD_W-1:0] e_d;
    logic [2:0]                 e_t, idx, t;
    logic [DTAG_W-1:0]          nt;
    int                         live;
    rsp_t                       r;
    do_reset();
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
    m_q.delete();
    m_last_byp = 1'b0;
    m_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      t = 3'($urandom_range(0, 7));
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_rw = m_vld[t] ? 1'b1 : ($urandom_range(0, 3) == 0);
      alloc_lane = 2'($urandom_range(0, 3)); alloc_wsel = 4'($urandom_range(0, 15)); alloc_tag = t;
      idx = 3'($urandom_range(0, 7));
      dram_rsp_valid = ($urandom_range(0, 1) == 1);
      dram_rsp_data = rand_line();
      if (m_vld[idx] || $urandom_range(0, 39) == 0) begin
        dram_rsp_tag = byp_tag(int'(idx));
      end else begin
        nt = 26'($urandom);
        nt[DTAG_W-1] = 1'b0;
        dram_rsp_tag = nt;
      end
      cache_dram_rsp_ready = ($urandom_range(0, 1) == 1);
      cache_core_rsp_valid = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      cache_core_rsp_data = {$urandom, $urandom, $urandom, $urandom};
      cache_core_rsp_tag = 3'($urandom);
      core_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      byp = (dram_rsp_tag[DTAG_W-1 -: 3] == 3'b111);
      e_ready = byp ? (m_q.size() < 2) : cache_dram_rsp_ready;
      gb = (m_q.size() > 0) && (cache_core_rsp_valid == 4'b0000 || !m_last_byp);
      if (gb) begin
        r = m_q[0];
        e_v = 4'(1 << r.lane);
        e_d = (NUM_REQS*WORD_W)'(r.word) << (WORD_W * int'(r.lane));
        e_t = r.tag;
        e_cr = 1'b0;
      end else begin
        e_v = cache_core_rsp_valid;
        e_d = cache_core_rsp_data;
        e_t = cache_core_rsp_tag;
        e_cr = core_rsp_ready;
      end
      live = 0;
      for (int i = 0; i < ENTRIES; i++) live += int'(m_vld[i]);
      n_checks++; if (dram_rsp_ready !== e_ready) $display("FAIL rnd_dram_ready cyc%0d: got %b exp %b", cyc, dram_rsp_ready, e_ready); else n_pass++;
      n_checks++; if (cache_dram_rsp_valid !== (dram_rsp_valid & !byp)) $display("FAIL rnd_cdram_valid cyc%0d: got %b exp %b", cyc, cache_dram_rsp_valid, dram_rsp_valid & !byp); else n_pass++;
      n_checks++; if (core_rsp_valid !== e_v) $display("FAIL rnd_core_valid cyc%0d: got %b exp %b", cyc, core_rsp_valid, e_v); else n_pass++;
      if (e_v != 4'b0000) begin
        n_checks++; if (core_rsp_data !== e_d) $display("FAIL rnd_core_data cyc%0d: got %h exp %h", cyc, core_rsp_data, e_d); else n_pass++;
        n_checks++; if (core_rsp_tag !== e_t) $display("FAIL rnd_core_tag cyc%0d: got %0d exp %0d", cyc, core_rsp_tag, e_t); else n_pass++;
      end
      n_checks++; if (cache_core_rsp_ready !== e_cr) $display("FAIL rnd_cc_ready cyc%0d: got %b exp %b", cyc, cache_core_rsp_ready, e_cr); else n_pass++;
      n_checks++; if (pending_cnt !== 4'(live)) $display("FAIL rnd_pending cyc%0d: got %0d exp %0d", cyc, pending_cnt, live); else n_pass++;
      n_checks++; if (bypass_err !== m_err) $display("FAIL rnd_err cyc%0d: got %b exp %b", cyc, bypass_err, m_err); else n_pass++;
      if (core_rsp_ready) begin
        if (gb) begin
          void'(m_q.pop_front());
          m_last_byp = 1'b1;
        end else if (cache_core_rsp_valid != 4'b0000) begin
          m_last_byp = 1'b0;
        end
      end
      if (dram_rsp_valid && byp && e_ready) begin
        idx = dram_rsp_tag[2:0];
        if (m_vld[idx]) begin
          r.lane = m_lane[idx];
          r.word = dram_rsp_data[int'(m_wsel[idx])*WORD_W +: WORD_W];
          r.tag  = m_tag[idx];
          m_q.push_back(r);
          m_vld[idx] = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (alloc_valid && !alloc_rw) begin
        if (m_vld[alloc_tag]) m_err = 1'b1;
        m_vld[alloc_tag] = 1'b1;
        m_lane[alloc_tag] = alloc_lane;
        m_wsel[alloc_tag] = alloc_wsel;
        m_tag[alloc_tag] = alloc_tag;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_bypass_read();
    test_passthrough();
    test_empty_entry();
    test_back_to_back();
    test_fairness();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
